// File: rtl/fp_pkg.sv
// Shared FP32 field layout, constants and arbiter state encoding for the
// battery-management multiply path.
package fp_pkg;

    localparam int FP_EXP_BIAS = 127;
    localparam int FP_EXP_W    = 8;
    localparam int FP_FRAC_W   = 23;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fp32_mul_core.sv
// Combinational FP32 multiplier: truncating, no special values, any zero
// exponent field forces a signed zero result.
module fp32_mul_core
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    fp32_t                fa;
    fp32_t                fb;
    fp32_t                fp;
    logic [47:0]          prod;
    logic                 exp_inc;
    logic [FP_FRAC_W-1:0] frac_n;
    logic [FP_EXP_W-1:0]  exp_n;

    // Returns {exponent increment, truncated fraction} for a 2.46 mantissa product.
    function automatic logic [FP_FRAC_W:0] trunc_norm(input logic [47:0] m);
        if (m[47]) begin
            return {1'b1, m[46:24]};
        end
        return {1'b0, m[45:23]};
    endfunction

    always_comb begin
        fa = fp32_t'(a);
        fb = fp32_t'(b);
        prod = 48'({1'b1, fa.frac}) * 48'({1'b1, fb.frac});
        {exp_inc, frac_n} = trunc_norm(prod);
        exp_n = fa.exp + fb.exp - 8'(FP_EXP_BIAS) + {7'd0, exp_inc};
        fp.sign = fa.sign ^ fb.sign;
        fp.exp  = exp_n;
        fp.frac = frac_n;
        if (fa.exp == '0 || fb.exp == '0) begin
            fp.exp  = '0;
            fp.frac = '0;
        end
        p = fp;
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one FP32 multiplier between NREQ requesters;
// products return on a single valid/ready channel tagged with requester ID.
module fp_mul_arbiter
    import fp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int XLEN = 32,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [XLEN-1:0]      rsp_result,
    output logic                 busy,
    output logic [15:0]          op_count
);

    arb_state_t      state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_found;
    logic            vld_p1;
    logic [XLEN-1:0] a_p0;
    logic [XLEN-1:0] b_p0;
    logic [IDW-1:0]  id_p0;
    logic [XLEN-1:0] prod_p0;

    // Scan ptr+NREQ down to ptr+1 so the nearest valid requester after ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(ptr) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign busy      = (state != IDLE);
    assign rsp_valid = vld_p1;

    // Stage p0: operand capture on grant
    always_ff @(posedge clk) begin
        if (state == IDLE && gnt_found) begin
            a_p0  <= req_a[gnt_idx*XLEN +: XLEN];
            b_p0  <= req_b[gnt_idx*XLEN +: XLEN];
            id_p0 <= gnt_idx;
        end
    end

    fp32_mul_core u_mul (
        .a (a_p0),
        .b (b_p0),
        .p (prod_p0)
    );

    // Stage p1: registered product and handshake control
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IDW'(NREQ - 1);
            vld_p1     <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    rsp_result <= prod_p0;
                    rsp_id     <= id_p0;
                    ptr        <= id_p0;
                    vld_p1     <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        vld_p1   <= 1'b0;
                        op_count <= op_count + 16'd1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    vld_p1 <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
